// File: rtl/dm_if.sv
// Request/response bus between the CPU datapath and the pipelined data memory.
interface dm_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        size;
    logic              sign_read;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wd;
    logic [ADDR_W-1:0] wpc;
    logic              rsp_valid;
    logic [31:0]       rd;
    logic              align_err;
    logic              range_err;

    modport master (
        output req_valid, req_write, size, sign_read, addr, wd, wpc,
        input  req_ready, rsp_valid, rd, align_err, range_err
    );

    modport slave (
        input  req_valid, req_write, size, sign_read, addr, wd, wpc,
        output req_ready, rsp_valid, rd, align_err, range_err
    );
endinterface

// File: rtl/dm_pipelined.sv
// Pipelined data memory: byte/half/word access, power-up clear sequencer, fault reporting.
// Optional store trace compiled in with DM_WRITE_LOG_EN.
module dm_pipelined #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned ADDR_W = 32
) (
    input logic  clk,
    input logic  rst,
    dm_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * DEPTH);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] rd;
        logic        align_err;
        logic        range_err;
    } rsp_t;

    state_t          state, state_next;
    logic [AW-1:0]   clr_ptr;
    logic [31:0]     mem [DEPTH];
    logic            req_ready;

    logic            accept;
    logic            align_err, range_err, fault;
    logic [AW-1:0]   widx;
    logic [4:0]      lane_sh;
    logic [31:0]     word_rd, shifted, lane_mask, load_ext, store_word;

    logic            mem_we;
    logic [AW-1:0]   mem_idx;
    logic [31:0]     mem_wdata;
    logic            ready_next;

    rsp_t            rsp_in;
    rsp_t            pipe [RD_LAT];

    // State register and clear pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == S_CLEAR)
                clr_ptr <= clr_ptr + AW'(1);
        end
    end

    // Next-state: leave CLEAR once the last word has been zeroed
    always_comb begin
        state_next = state;
        if (state == S_CLEAR && clr_ptr == AW'(DEPTH - 1))
            state_next = S_RUN;
    end

    // Output decode: memory write port and ready
    always_comb begin
        mem_we     = 1'b0;
        mem_idx    = widx;
        mem_wdata  = store_word;
        ready_next = (state_next == S_RUN);
        case (state)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_idx   = clr_ptr;
                mem_wdata = '0;
            end
            S_RUN: mem_we = accept & bus.req_write & ~fault;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) req_ready <= 1'b0;
        else     req_ready <= ready_next;
    end

    // Request decode, lane extraction and store merge
    always_comb begin
        accept  = bus.req_valid & req_ready;
        widx    = bus.addr[AW+1:2];
        lane_sh = {bus.addr[1:0], 3'b000};
        word_rd = mem[widx];
        shifted = word_rd >> lane_sh;

        case (bus.size)
            2'd0:    align_err = (bus.addr[1:0] != 2'b00);
            2'd1:    align_err = bus.addr[0];
            2'd2:    align_err = 1'b0;
            default: align_err = 1'b1;
        endcase
        range_err = ({1'b0, bus.addr} >= ADDR_LIMIT);
        fault     = align_err | range_err;

        case (bus.size)
            2'd0:    lane_mask = 32'hffff_ffff;
            2'd1:    lane_mask = 32'h0000_ffff;
            default: lane_mask = 32'h0000_00ff;
        endcase

        case (bus.size)
            2'd0:    load_ext = shifted;
            2'd1:    load_ext = {{16{bus.sign_read & shifted[15]}}, shifted[15:0]};
            2'd2:    load_ext = {{24{bus.sign_read & shifted[7]}}, shifted[7:0]};
            default: load_ext = '0;
        endcase

        store_word = (word_rd & ~(lane_mask << lane_sh)) | ((bus.wd & lane_mask) << lane_sh);

        rsp_in.valid     = accept;
        rsp_in.rd        = (accept & ~bus.req_write & ~fault) ? load_ext : 32'h0;
        rsp_in.align_err = accept & align_err;
        rsp_in.range_err = accept & range_err;
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_idx] <= mem_wdata;
    end

    // Response latency pipeline; reset drops everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RD_LAT); i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= rsp_in;
            for (int i = 1; i < int'(RD_LAT); i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = pipe[RD_LAT-1].valid;
    assign bus.rd        = pipe[RD_LAT-1].rd;
    assign bus.align_err = pipe[RD_LAT-1].align_err;
    assign bus.range_err = pipe[RD_LAT-1].range_err;

`ifdef DM_WRITE_LOG_EN
    always_ff @(posedge clk) begin
        if (!rst && state == S_RUN && mem_we)
            $display("%t @%h: *%h <= %h", $time, bus.wpc,
                     {bus.addr[ADDR_W-1:2], 2'b00}, mem_wdata);
    end
`else
    logic unused_wpc;
    assign unused_wpc = ^bus.wpc;
`endif

endmodule

// File: tb/tb_dm_pipelined.sv
// Randomized self-checking bench for dm_pipelined against a behavioural memory model.
module tb_dm_pipelined;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned RD_LAT = 3;
    localparam int unsigned AW     = $clog2(DEPTH);

    typedef struct {
        int unsigned due;
        logic [31:0] rd;
        logic        ae;
        logic        re;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dm_if #(.ADDR_W(32)) bif ();

    dm_pipelined #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    int          tests  = 0;
    int          failed = 0;
    int unsigned cyc    = 0;
    int unsigned since  = 0;
    logic [31:0] model_mem [DEPTH];
    exp_t        expq [$];
    int unsigned log_cyc [$];
    logic [31:0] log_rd [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour: plain arithmetic on a word array
    function automatic exp_t model_access(input logic w, input logic [1:0] sz, input logic sg,
                                          input logic [31:0] a, input logic [31:0] d);
        exp_t          e;
        int unsigned   sh;
        logic [31:0]   lm, v;
        logic [AW-1:0] idx;
        e.due = 0;
        e.rd  = 32'h0;
        e.ae  = (sz == 2'd3) || (sz == 2'd0 && (a % 4) != 0) || (sz == 2'd1 && (a % 2) != 0);
        e.re  = (a >= 4 * DEPTH);
        if (!e.ae && !e.re) begin
            idx = a[AW+1:2];
            sh  = (a % 4) * 8;
            lm  = (sz == 2'd0) ? 32'hffff_ffff : (sz == 2'd1) ? 32'h0000_ffff : 32'h0000_00ff;
            if (w) begin
                model_mem[idx] = (model_mem[idx] & ~(lm << sh)) | ((d & lm) << sh);
            end else begin
                v = (model_mem[idx] >> sh) & lm;
                if (sg && sz == 2'd1 && v[15]) v = v | 32'hffff_0000;
                if (sg && sz == 2'd2 && v[7])  v = v | 32'hffff_ff00;
                e.rd = v;
            end
        end
        return e;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) since = 0;
        else     since++;
    end

    // Compare process: outputs every cycle, then predict the next accept
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            expq.delete();
            for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 32'h0;
            chk("rst_ready", 32'(bif.req_ready), 32'h0);
            chk("rst_rsp_valid", 32'(bif.rsp_valid), 32'h0);
            chk("rst_rd", bif.rd, 32'h0);
            chk("rst_errs", {30'h0, bif.align_err, bif.range_err}, 32'h0);
        end else begin
            chk("req_ready", 32'(bif.req_ready), 32'(since >= DEPTH));
            if (expq.size() > 0 && expq[0].due == cyc) begin
                e = expq.pop_front();
                chk("rsp_valid", 32'(bif.rsp_valid), 32'h1);
                chk("rsp_rd", bif.rd, e.rd);
                chk("rsp_align_err", 32'(bif.align_err), 32'(e.ae));
                chk("rsp_range_err", 32'(bif.range_err), 32'(e.re));
            end else begin
                chk("rsp_idle", 32'(bif.rsp_valid), 32'h0);
            end
            if (bif.rsp_valid) begin
                log_cyc.push_back(cyc);
                log_rd.push_back(bif.rd);
            end
            if (bif.req_valid && since >= DEPTH) begin
                e = model_access(bif.req_write, bif.size, bif.sign_read, bif.addr, bif.wd);
                e.due = cyc + RD_LAT;
                expq.push_back(e);
            end
        end
    end

    task automatic drive(input logic v, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
        bif.req_valid = v;
        bif.req_write = w;
        bif.size      = sz;
        bif.sign_read = sg;
        bif.addr      = a;
        bif.wd        = d;
        bif.wpc       = $urandom;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bif.req_ready && n < int'(4 * DEPTH)) begin
            step();
            n++;
        end
        if (!bif.req_ready) chk("ready_timeout", 32'h0, 32'h1);
    endtask

    // One request, then its response checked against hand-computed literals
    task automatic check_req(input string name, input logic w, input logic [1:0] sz,
                             input logic sg, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp_rd, input logic exp_ae, input logic exp_re);
        logic got = 1'b0;
        drive(1'b1, w, sz, sg, a, d);
        step();
        idle();
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bif.rsp_valid) got = 1'b1;
        end
        if (!got) begin
            chk({name, "_timeout"}, 32'h0, 32'h1);
        end else begin
            chk({name, "_rd"}, bif.rd, exp_rd);
            chk({name, "_errs"}, {30'h0, bif.align_err, bif.range_err}, {30'h0, exp_ae, exp_re});
        end
        step();
    endtask

    initial begin
        int          cnt;
        int unsigned a0;
        idle();
        repeat (3) step();
        rst = 1'b0;

        // Clear sequencer holds ready low for exactly DEPTH cycles
        cnt = 0;
        while (cnt < int'(4 * DEPTH)) begin
            @(negedge clk);
            if (bif.req_ready) break;
            cnt++;
        end
        chk("clear_cycles", 32'(cnt), 32'(DEPTH));
        step();
        check_req("load_after_clear", 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0);

        // Partial store merge and extension
        check_req("st_w0",  1'b1, 2'd0, 1'b0, 32'h0, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
        check_req("st_h2",  1'b1, 2'd1, 1'b0, 32'h2, 32'h0000_aabb, 32'h0, 1'b0, 1'b0);
        check_req("st_b0",  1'b1, 2'd2, 1'b0, 32'h0, 32'haabb_ccdd, 32'h0, 1'b0, 1'b0);
        check_req("st_b3",  1'b1, 2'd2, 1'b0, 32'h3, 32'haabb_ccee, 32'h0, 1'b0, 1'b0);
        check_req("ld_w0",  1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'heebb_56dd, 1'b0, 1'b0);
        check_req("ld_b0s", 1'b0, 2'd2, 1'b1, 32'h0, 32'h0, 32'hffff_ffdd, 1'b0, 1'b0);
        check_req("ld_b0u", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0000_00dd, 1'b0, 1'b0);
        check_req("ld_h2s", 1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 32'hffff_eebb, 1'b0, 1'b0);
        check_req("ld_h0u", 1'b0, 2'd1, 1'b0, 32'h0, 32'h0, 32'h0000_56dd, 1'b0, 1'b0);

        // Faults
        check_req("st_misalign", 1'b1, 2'd0, 1'b0, 32'h2, 32'hdead_beef, 32'h0, 1'b1, 1'b0);
        check_req("ld_unchanged", 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'heebb_56dd, 1'b0, 1'b0);
        check_req("ld_range", 1'b0, 2'd0, 1'b0, 32'(4 * DEPTH), 32'h0, 32'h0, 1'b0, 1'b1);
        check_req("ld_size3", 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_req("ld_both", 1'b0, 2'd1, 1'b0, 32'(4 * DEPTH + 1), 32'h0, 32'h0, 1'b1, 1'b1);

        // Back-to-back loads stream out in consecutive cycles
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b1, 2'd0, 1'b0, 32'(16 + 4 * k), 32'h1111_1111 * 32'(k + 1));
            step();
        end
        idle();
        repeat (RD_LAT + 2) step();
        log_cyc.delete();
        log_rd.delete();
        a0 = 0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, 2'd0, 1'b0, 32'(16 + 4 * k), 32'h0);
            step();
            if (k == 0) a0 = cyc;
        end
        idle();
        repeat (RD_LAT + 4) step();
        chk("burst_count", 32'(log_cyc.size()), 32'd6);
        if (log_cyc.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                chk("burst_cycle", log_cyc[k], a0 + 2 + 32'(k));
                chk("burst_rd", log_rd[k], 32'h1111_1111 * 32'(k + 1));
            end
        end

        // Reset with two loads in flight
        check_req("st_w8", 1'b1, 2'd0, 1'b0, 32'h8, 32'hcafe_f00d, 32'h0, 1'b0, 1'b0);
        log_cyc.delete();
        drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h8, 32'h0);
        step();
        drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h4, 32'h0);
        step();
        rst = 1'b1;
        idle();
        repeat (2) step();
        rst = 1'b0;
        wait_ready();
        chk("no_rsp_after_rst", 32'(log_cyc.size()), 32'd0);
        check_req("ld_w8_cleared", 1'b0, 2'd0, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, 1'b0);

        // Random traffic, checked by the compare process
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a = 32'($urandom_range(0, 4 * DEPTH + 5));
            if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
            drive(($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom_range(0, 3)),
                  1'($urandom), a, $urandom);
            step();
        end
        idle();
        repeat (RD_LAT + 4) step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
